alu_seq: RTL and testbench

- Handshaked, parametrised successor to the team's combinational 32-bit ALU.
- Operands and opcode enter through a valid/ready port. Logic and add/sub/compare/shift ops complete in 1 cycle; unsigned multiply runs as an iterative shift-add over WIDTH cycles.
- The result and flags (ZF, OF, CF) are registered and held until the consumer accepts them.
- Sits between the operand/instruction source and the result sink or 7-segment display driver.

---
 rtl/alu_pkg.sv | 29 ++
 rtl/alu_mul_iter.sv | 52 +++++
 rtl/alu_seq.sv | 127 ++++++++++++
 tb/tb_alu_seq.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - opcodes, FSM state encoding and status-word flag indices for alu_seq
package alu_pkg;

  localparam logic [3:0] OP_AND  = 4'd0;
  localparam logic [3:0] OP_OR   = 4'd1;
  localparam logic [3:0] OP_XOR  = 4'd2;
  localparam logic [3:0] OP_XNOR = 4'd3;
  localparam logic [3:0] OP_ADD  = 4'd4;
  localparam logic [3:0] OP_SUB  = 4'd5;
  localparam logic [3:0] OP_SLT  = 4'd6;
  localparam logic [3:0] OP_SLTU = 4'd7;
  localparam logic [3:0] OP_SLL  = 4'd8;
  localparam logic [3:0] OP_SRL  = 4'd9;
  localparam logic [3:0] OP_SRA  = 4'd10;
  localparam logic [3:0] OP_MUL  = 4'd11;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    DONE = 2'd2
  } state_t;

  // Bit positions in the status word consumed by the display driver
  localparam int FLAG_ZF = 0;
  localparam int FLAG_OF = 1;
  localparam int FLAG_CF = 2;
  localparam int FLAG_W  = 3;

endpackage

// File: rtl/alu_mul_iter.sv
// rtl/alu_mul_iter.sv - iterative shift-add unsigned multiplier, one partial product per cycle
module alu_mul_iter #(
  parameter int WIDTH = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               done,
  output logic [2*WIDTH-1:0] product
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  logic               active;
  logic [CW-1:0]      count;
  logic [2*WIDTH-1:0] acc;
  logic [2*WIDTH-1:0] mcand;
  logic [WIDTH-1:0]   mplier;

  // product is the accumulator value after this edge, so the caller can
  // register the final result on the same edge that done is high
  always_comb begin
    product = mplier[0] ? acc + mcand : acc;
    done    = active && (count == LAST);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      active <= 1'b0;
      count  <= '0;
      acc    <= '0;
      mcand  <= '0;
      mplier <= '0;
    end else if (start) begin
      active <= 1'b1;
      count  <= '0;
      acc    <= '0;
      mcand  <= {{WIDTH{1'b0}}, a};
      mplier <= b;
    end else if (active) begin
      acc    <= product;
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
      count  <= count + 1'b1;
      if (done) active <= 1'b0;
    end
  end

endmodule

// File: rtl/alu_seq.sv
// rtl/alu_seq.sv - handshaked ALU with registered result/flags and an iterative multiply
module alu_seq
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [3:0]       ALU_OP,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] F,
  output logic             ZF,
  output logic             OF,
  output logic             CF,
  output logic             busy
);

  localparam int SH_W = $clog2(WIDTH);

  state_t               state, state_nxt;
  logic                 accept, is_mul, mul_start, mul_done;
  logic [2*WIDTH-1:0]   product;
  logic [WIDTH-1:0]     res;
  logic                 res_of, res_cf;
  logic [WIDTH:0]       sum, diff;
  logic [SH_W-1:0]      sh;
  logic [FLAG_W-1:0]    flags;

  always_comb begin
    res    = '0;
    res_of = 1'b0;
    res_cf = 1'b0;
    sum    = {1'b0, A} + {1'b0, B};
    diff   = {1'b0, A} - {1'b0, B};
    sh     = A[SH_W-1:0];
    case (ALU_OP)
      OP_AND:  res = A & B;
      OP_OR:   res = A | B;
      OP_XOR:  res = A ^ B;
      OP_XNOR: res = ~(A ^ B);
      OP_ADD: begin
        res    = sum[WIDTH-1:0];
        res_cf = sum[WIDTH];
        res_of = (A[WIDTH-1] == B[WIDTH-1]) && (sum[WIDTH-1] != A[WIDTH-1]);
      end
      OP_SUB: begin
        res    = diff[WIDTH-1:0];
        res_cf = diff[WIDTH];
        res_of = (A[WIDTH-1] != B[WIDTH-1]) && (diff[WIDTH-1] != A[WIDTH-1]);
      end
      OP_SLT:  res = {{(WIDTH-1){1'b0}}, $signed(A) < $signed(B)};
      OP_SLTU: res = {{(WIDTH-1){1'b0}}, A < B};
      OP_SLL:  res = B << sh;
      OP_SRL:  res = B >> sh;
      OP_SRA:  res = $signed(B) >>> sh;
      default: res = '0;
    endcase
  end

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    case (state)
      IDLE:    in_ready = 1'b1;
      EXEC:    busy = 1'b1;
      DONE: begin
        out_valid = 1'b1;
        in_ready  = out_ready;
      end
      default: in_ready = 1'b0;
    endcase
    is_mul    = (ALU_OP == OP_MUL);
    accept    = in_valid && in_ready;
    mul_start = accept && is_mul;
    if (accept) begin
      state_nxt = is_mul ? EXEC : DONE;
    end else if (state == EXEC && mul_done) begin
      state_nxt = DONE;
    end else if (state == DONE && out_ready) begin
      state_nxt = IDLE;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) state <= IDLE;
    else     state <= state_nxt;
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      F     <= '0;
      flags <= '0;
    end else if (accept && !is_mul) begin
      F              <= res;
      flags[FLAG_ZF] <= (res == '0);
      flags[FLAG_OF] <= res_of;
      flags[FLAG_CF] <= res_cf;
    end else if (mul_done) begin
      F              <= product[WIDTH-1:0];
      flags[FLAG_ZF] <= (product[WIDTH-1:0] == '0);
      flags[FLAG_OF] <= |product[2*WIDTH-1:WIDTH];
      flags[FLAG_CF] <= 1'b0;
    end
  end

  assign ZF = flags[FLAG_ZF];
  assign OF = flags[FLAG_OF];
  assign CF = flags[FLAG_CF];

  alu_mul_iter #(.WIDTH(WIDTH)) u_mul (
    .clk     (CLK),
    .rst     (RST),
    .start   (mul_start),
    .a       (A),
    .b       (B),
    .done    (mul_done),
    .product (product)
  );

endmodule

// File: tb/tb_alu_seq.sv
// tb/tb_alu_seq.sv - directed bench for alu_seq at WIDTH=32 and WIDTH=8
module tb_alu_seq;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;

  logic        in_valid = 1'b0, out_ready = 1'b0;
  logic [31:0] A = '0, B = '0;
  logic [3:0]  ALU_OP = '0;
  logic        in_ready, out_valid, ZF, OF, CF, busy;
  logic [31:0] F;

  logic        w8_in_valid = 1'b0, w8_out_ready = 1'b1;
  logic [7:0]  w8_A = '0, w8_B = '0;
  logic [3:0]  w8_op = '0;
  logic        w8_in_ready, w8_out_valid, w8_ZF, w8_OF, w8_CF, w8_busy;
  logic [7:0]  w8_F;

  int vectors = 0;
  int miscompares = 0;
  int n;

  always #5 CLK = ~CLK;

  alu_seq #(.WIDTH(32)) dut (
    .CLK(CLK), .RST(RST), .in_valid(in_valid), .in_ready(in_ready),
    .A(A), .B(B), .ALU_OP(ALU_OP), .out_valid(out_valid), .out_ready(out_ready),
    .F(F), .ZF(ZF), .OF(OF), .CF(CF), .busy(busy)
  );

  alu_seq #(.WIDTH(8)) dut8 (
    .CLK(CLK), .RST(RST), .in_valid(w8_in_valid), .in_ready(w8_in_ready),
    .A(w8_A), .B(w8_B), .ALU_OP(w8_op), .out_valid(w8_out_valid), .out_ready(w8_out_ready),
    .F(w8_F), .ZF(w8_ZF), .OF(w8_OF), .CF(w8_CF), .busy(w8_busy)
  );

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    ALU_OP   = op;
    A        = a;
    B        = b;
    in_valid = 1'b1;
  endtask

  initial begin
    #1;
    chk("rst_F", F, 0);
    chk("rst_ZF", ZF, 0);
    chk("rst_OF", OF, 0);
    chk("rst_CF", CF, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_in_ready", in_ready, 1);
    step();
    step();
    RST = 1'b0;
    out_ready = 1'b1;

    // ADD signed overflow
    issue(4'd4, 32'h7FFF_FFFF, 32'h1);
    step();
    in_valid = 1'b0;
    chk("add_valid", out_valid, 1);
    chk("add_F", F, 64'h8000_0000);
    chk("add_OF", OF, 1);
    chk("add_CF", CF, 0);
    chk("add_ZF", ZF, 0);

    // back-to-back SUBs
    issue(4'd5, 32'd5, 32'd5);
    chk("sub1_in_ready", in_ready, 1);
    step();
    chk("sub1_F", F, 0);
    chk("sub1_ZF", ZF, 1);
    chk("sub1_CF", CF, 0);
    chk("sub1_valid", out_valid, 1);
    issue(4'd5, 32'd0, 32'd1);
    chk("sub2_in_ready", in_ready, 1);
    step();
    in_valid = 1'b0;
    chk("sub2_F", F, 64'hFFFF_FFFF);
    chk("sub2_CF", CF, 1);
    chk("sub2_OF", OF, 0);
    chk("sub2_ZF", ZF, 0);
    chk("sub2_in_ready", in_ready, 1);
    step();
    chk("idle_after_sub", out_valid, 0);

    // MUL with upper-half overflow, busy for exactly 32 cycles
    issue(4'd11, 32'h0001_0000, 32'h0001_0000);
    step();
    in_valid = 1'b0;
    chk("mul1_busy", busy, 1);
    chk("mul1_in_ready", in_ready, 0);
    chk("mul1_valid_low", out_valid, 0);
    n = 0;
    while (busy && n < 100) begin
      n++;
      step();
    end
    chk("mul1_busy_cycles", n, 32);
    chk("mul1_valid", out_valid, 1);
    chk("mul1_F", F, 0);
    chk("mul1_ZF", ZF, 1);
    chk("mul1_OF", OF, 1);
    chk("mul1_CF", CF, 0);

    issue(4'd11, 32'd1234, 32'd5678);
    step();
    in_valid = 1'b0;
    n = 0;
    while (!out_valid && n < 100) begin
      n++;
      step();
    end
    chk("mul2_done_in_time", n < 100, 1);
    chk("mul2_F", F, 64'd7006652);
    chk("mul2_OF", OF, 0);
    step();

    // SRA under backpressure, competing offers ignored
    out_ready = 1'b0;
    issue(4'd10, 32'd4, 32'h8000_0000);
    step();
    issue(4'd4, 32'd1, 32'd1);
    for (int i = 0; i < 5; i++) begin
      chk("bp_F", F, 64'hF800_0000);
      chk("bp_valid", out_valid, 1);
      chk("bp_in_ready", in_ready, 0);
      step();
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    step();
    chk("bp_release_valid", out_valid, 0);
    chk("bp_release_in_ready", in_ready, 1);
    chk("bp_release_busy", busy, 0);

    // async reset 10 cycles into a multiply
    issue(4'd11, 32'd1234, 32'd5678);
    step();
    in_valid = 1'b0;
    repeat (9) step();
    chk("pre_rst_busy", busy, 1);
    #2 RST = 1'b1;
    #1;
    chk("arst_F", F, 0);
    chk("arst_busy", busy, 0);
    chk("arst_valid", out_valid, 0);
    chk("arst_in_ready", in_ready, 1);
    step();
    RST = 1'b0;

    issue(4'd7, 32'd1, 32'hFFFF_FFFF);
    step();
    chk("sltu_F", F, 1);
    issue(4'd6, 32'd1, 32'hFFFF_FFFF);
    step();
    in_valid = 1'b0;
    chk("slt_F", F, 0);
    chk("slt_ZF", ZF, 1);

    // WIDTH=8 instance: shift amount uses A[2:0], reserved opcode
    w8_op = 4'd8;
    w8_A = 8'h0B;
    w8_B = 8'h81;
    w8_in_valid = 1'b1;
    step();
    chk("w8_sll_valid", w8_out_valid, 1);
    chk("w8_sll_F", w8_F, 8'h08);
    w8_op = 4'd13;
    w8_A = 8'h5A;
    w8_B = 8'hA5;
    step();
    w8_in_valid = 1'b0;
    chk("w8_rsv_F", w8_F, 0);
    chk("w8_rsv_ZF", w8_ZF, 1);
    chk("w8_rsv_OF", w8_OF, 0);
    chk("w8_rsv_CF", w8_CF, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
